// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped table of 2-bit saturating counters with a tagged
// branch target buffer, plus saturating branch / mispredict performance counters.
//
// Ports:
//   clk, rst            core clock, asynchronous active-low reset
//   fetch_pc            PC being fetched this cycle
//   pred_taken          combinational taken prediction for fetch_pc
//   pred_target         combinational next-PC candidate (target on taken, else fetch_pc+1)
//   upd_valid           execute stage resolves a control instruction this cycle
//   upd_is_branch       resolved instruction is a conditional branch (jumps drive 0)
//   upd_pc              PC of the resolved instruction
//   upd_taken           actual outcome
//   upd_target          actual branch target
//   upd_mispredict      the earlier prediction for this branch was wrong
//   branch_count        resolved conditional branches (saturating)
//   mispredict_count    mispredicted conditional branches (saturating)
module branch_predictor #(
   parameter int unsigned PC_W  = 10,
   parameter int unsigned IDX_W = 4,
   parameter int unsigned TAG_W = PC_W - IDX_W,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PC_W-1:0]  fetch_pc,
   output logic             pred_taken,
   output logic [PC_W-1:0]  pred_target,
   input  logic             upd_valid,
   input  logic             upd_is_branch,
   input  logic [PC_W-1:0]  upd_pc,
   input  logic             upd_taken,
   input  logic [PC_W-1:0]  upd_target,
   input  logic             upd_mispredict,
   output logic [CNT_W-1:0] branch_count,
   output logic [CNT_W-1:0] mispredict_count
);

   localparam int unsigned Entries = 2 ** IDX_W;

   typedef enum logic [1:0] {
      Snt = 2'b00,
      Wnt = 2'b01,
      Wt  = 2'b10,
      St  = 2'b11
   } ctr_e;

   logic             valid_q  [Entries];
   logic [TAG_W-1:0] tag_q    [Entries];
   ctr_e             ctr_q    [Entries];
   logic [PC_W-1:0]  target_q [Entries];

   logic [CNT_W-1:0] branch_count_q;
   logic [CNT_W-1:0] mispredict_count_q;

   // ---------------------------------------------------------------- lookup
   logic [IDX_W-1:0] f_idx;
   logic [TAG_W-1:0] f_tag;
   logic             f_hit;

   assign f_idx = fetch_pc[IDX_W-1:0];
   assign f_tag = fetch_pc[PC_W-1:IDX_W];
   assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

   // Reads only registered state, so a same-cycle update to this index is not bypassed.
   assign pred_taken  = f_hit && ((ctr_q[f_idx] == Wt) || (ctr_q[f_idx] == St));
   assign pred_target = pred_taken ? target_q[f_idx] : fetch_pc + PC_W'(1);

   // ---------------------------------------------------------------- update
   logic             upd_en;
   logic [IDX_W-1:0] u_idx;
   logic [TAG_W-1:0] u_tag;
   logic             u_hit;
   ctr_e             ctr_d;
   logic [PC_W-1:0]  target_d;

   assign upd_en = upd_valid && upd_is_branch;
   assign u_idx  = upd_pc[IDX_W-1:0];
   assign u_tag  = upd_pc[PC_W-1:IDX_W];
   assign u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

   always_comb begin
      // Allocation defaults: a new entry starts weakly biased toward its first outcome.
      ctr_d    = upd_taken ? Wt : Wnt;
      target_d = upd_target;
      if (u_hit) begin
         unique case (ctr_q[u_idx])
            Snt:     ctr_d = upd_taken ? Wnt : Snt;
            Wnt:     ctr_d = upd_taken ? Wt  : Snt;
            Wt:      ctr_d = upd_taken ? St  : Wnt;
            St:      ctr_d = upd_taken ? St  : Wt;
            default: ctr_d = Wnt;
         endcase
         // A not-taken hit keeps the previously learned target.
         if (!upd_taken) begin
            target_d = target_q[u_idx];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < Entries; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            ctr_q[i]    <= Wnt;
            target_q[i] <= '0;
         end
      end else if (upd_en) begin
         valid_q[u_idx]  <= 1'b1;
         tag_q[u_idx]    <= u_tag;
         ctr_q[u_idx]    <= ctr_d;
         target_q[u_idx] <= target_d;
      end
   end

   // ---------------------------------------------------------------- perf counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         branch_count_q     <= '0;
         mispredict_count_q <= '0;
      end else if (upd_en) begin
         if (branch_count_q != '1) begin
            branch_count_q <= branch_count_q + CNT_W'(1);
         end
         if (upd_mispredict && (mispredict_count_q != '1)) begin
            mispredict_count_q <= mispredict_count_q + CNT_W'(1);
         end
      end
   end

   assign branch_count     = branch_count_q;
   assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by randomized traffic,
// compared against a behavioural table model. A second instance built with CNT_W=4 shares the
// same stimulus to exercise perf-counter saturation.
module tb_branch_predictor;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [9:0] fetch_pc = '0;
   logic       upd_valid = 1'b0;
   logic       upd_is_branch = 1'b0;
   logic [9:0] upd_pc = '0;
   logic       upd_taken = 1'b0;
   logic [9:0] upd_target = '0;
   logic       upd_mispredict = 1'b0;

   logic        pred_taken;
   logic [9:0]  pred_target;
   logic [15:0] branch_count;
   logic [15:0] mispredict_count;

   logic        s_pred_taken;
   logic [9:0]  s_pred_target;
   logic [3:0]  s_branch_count;
   logic [3:0]  s_mispredict_count;

   branch_predictor dut (
      .clk              (clk),
      .rst              (rst),
      .fetch_pc         (fetch_pc),
      .pred_taken       (pred_taken),
      .pred_target      (pred_target),
      .upd_valid        (upd_valid),
      .upd_is_branch    (upd_is_branch),
      .upd_pc           (upd_pc),
      .upd_taken        (upd_taken),
      .upd_target       (upd_target),
      .upd_mispredict   (upd_mispredict),
      .branch_count     (branch_count),
      .mispredict_count (mispredict_count)
   );

   branch_predictor #(.CNT_W(4)) dut_small (
      .clk              (clk),
      .rst              (rst),
      .fetch_pc         (fetch_pc),
      .pred_taken       (s_pred_taken),
      .pred_target      (s_pred_target),
      .upd_valid        (upd_valid),
      .upd_is_branch    (upd_is_branch),
      .upd_pc           (upd_pc),
      .upd_taken        (upd_taken),
      .upd_target       (upd_target),
      .upd_mispredict   (upd_mispredict),
      .branch_count     (s_branch_count),
      .mispredict_count (s_mispredict_count)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------- reference model
   bit m_valid  [16];
   int m_tag    [16];
   int m_ctr    [16];   // 0..3 confidence, >=2 means predict taken
   int m_target [16];
   int m_br;
   int m_mp;

   int n_checks = 0;
   int n_pass   = 0;

   function automatic int sat(input int v, input int lim);
      return (v > lim) ? lim : v;
   endfunction

   function automatic bit m_hit(input int pc);
      return m_valid[pc % 16] && (m_tag[pc % 16] == pc / 16);
   endfunction

   function automatic int m_taken(input int pc);
      return (m_hit(pc) && m_ctr[pc % 16] >= 2) ? 1 : 0;
   endfunction

   function automatic int m_tgt(input int pc);
      return m_taken(pc) ? m_target[pc % 16] : (pc + 1) % 1024;
   endfunction

   task automatic m_clear();
      for (int i = 0; i < 16; i++) begin
         m_valid[i]  = 1'b0;
         m_tag[i]    = 0;
         m_ctr[i]    = 1;
         m_target[i] = 0;
      end
      m_br = 0;
      m_mp = 0;
   endtask

   task automatic m_update();
      int pc;
      int idx;
      pc  = int'(upd_pc);
      idx = pc % 16;
      if (!(upd_valid && upd_is_branch)) return;
      if (m_hit(pc)) begin
         if (upd_taken) begin
            m_ctr[idx]    = sat(m_ctr[idx] + 1, 3);
            m_target[idx] = int'(upd_target);
         end else begin
            m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
         end
      end else begin
         m_valid[idx]  = 1'b1;
         m_tag[idx]    = pc / 16;
         m_ctr[idx]    = upd_taken ? 2 : 1;
         m_target[idx] = int'(upd_target);
      end
      m_br++;
      if (upd_mispredict) m_mp++;
   endtask

   // ---------------------------------------------------------------- checking
   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                    tag, obs, obs, exp, exp, $time);
   endtask

   task automatic check_outputs();
      check("pred_taken",    int'(pred_taken),         m_taken(int'(fetch_pc)));
      check("pred_target",   int'(pred_target),        m_tgt(int'(fetch_pc)));
      check("branch_count",  int'(branch_count),       sat(m_br, 65535));
      check("mispred_count", int'(mispredict_count),   sat(m_mp, 65535));
      check("s_pred_taken",  int'(s_pred_taken),       m_taken(int'(fetch_pc)));
      check("s_pred_target", int'(s_pred_target),      m_tgt(int'(fetch_pc)));
      check("s_branch_cnt",  int'(s_branch_count),     sat(m_br, 15));
      check("s_mispred_cnt", int'(s_mispredict_count), sat(m_mp, 15));
   endtask

   // One clock: drive at the falling edge, check pre-update outputs, let the edge apply.
   task automatic cycle(input bit v, input bit b, input int pc, input bit tk, input int tgt,
                        input bit mp, input int fpc);
      upd_valid      = v;
      upd_is_branch  = b;
      upd_pc         = 10'(pc);
      upd_taken      = tk;
      upd_target     = 10'(tgt);
      upd_mispredict = mp;
      fetch_pc       = 10'(fpc);
      #1;
      check_outputs();
      @(posedge clk);
      m_update();
      @(negedge clk);
   endtask

   task automatic br(input int pc, input bit tk, input int tgt);
      cycle(1'b1, 1'b1, pc, tk, tgt, 1'b0, pc);
   endtask

   // Lookup-only probe against hand-derived constants; no clock edge is consumed.
   task automatic peek(input string tag, input int fpc, input int exp_t, input int exp_tgt);
      upd_valid = 1'b0;
      fetch_pc  = 10'(fpc);
      #1;
      check({tag, "_taken"},  int'(pred_taken),  exp_t);
      check({tag, "_target"}, int'(pred_target), exp_tgt);
   endtask

   // Asynchronous reset asserted mid-cycle while an update is being presented.
   task automatic do_reset();
      #2;
      upd_valid     = 1'b1;
      upd_is_branch = 1'b1;
      rst           = 1'b0;
      #1;
      m_clear();
      check_outputs();
      @(posedge clk);
      @(negedge clk);
      upd_valid = 1'b0;
      #1 rst = 1'b1;
      @(negedge clk);
   endtask

   int pool [6];

   initial begin
      m_clear();
      #3;
      check_outputs();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Allocation (same-cycle lookup sees the pre-update entry)
      br(10'h013, 1'b1, 10'h040);
      peek("alloc_t", 10'h013, 1, 10'h040);
      br(10'h014, 1'b0, 10'h050);
      peek("alloc_nt", 10'h014, 0, 10'h015);

      // Hysteresis
      repeat (3) br(10'h013, 1'b1, 10'h040);
      br(10'h013, 1'b0, 10'h040);
      peek("hyst_wt", 10'h013, 1, 10'h040);
      br(10'h013, 1'b0, 10'h040);
      peek("hyst_wnt", 10'h013, 0, 10'h014);
      repeat (5) br(10'h013, 1'b0, 10'h040);
      br(10'h013, 1'b1, 10'h040);
      peek("hyst_snt", 10'h013, 0, 10'h014);

      // Aliasing on index 3
      repeat (2) br(10'h013, 1'b1, 10'h040);
      peek("alias_pre", 10'h013, 1, 10'h040);
      br(10'h023, 1'b0, 10'h060);
      peek("alias_evict", 10'h013, 0, 10'h014);
      peek("alias_new", 10'h023, 0, 10'h024);

      // PC+1 wrap
      peek("wrap", 10'h3FF, 0, 10'h000);

      // Perf counters: jumps and idle cycles must not count
      do_reset();
      cycle(1'b1, 1'b1, 10'h100, 1'b1, 10'h200, 1'b0, 10'h100);
      cycle(1'b1, 1'b1, 10'h101, 1'b0, 10'h300, 1'b1, 10'h101);
      cycle(1'b1, 1'b1, 10'h102, 1'b1, 10'h010, 1'b0, 10'h102);
      cycle(1'b1, 1'b0, 10'h103, 1'b1, 10'h050, 1'b1, 10'h103);
      cycle(1'b1, 1'b0, 10'h104, 1'b1, 10'h051, 1'b1, 10'h104);
      cycle(1'b0, 1'b1, 10'h105, 1'b1, 10'h052, 1'b1, 10'h105);
      check("perf_br", int'(branch_count), 3);
      check("perf_mp", int'(mispredict_count), 1);
      repeat (20) cycle(1'b1, 1'b1, 10'h0AA, 1'b1, 10'h0BB, 1'b1, 10'h000);
      check("sat_small_br", int'(s_branch_count), 15);
      check("sat_small_mp", int'(s_mispredict_count), 15);
      check("nosat_br", int'(branch_count), 23);
      check("nosat_mp", int'(mispredict_count), 21);

      // Reset after training to strongly taken
      repeat (3) br(10'h025, 1'b1, 10'h077);
      peek("trained", 10'h025, 1, 10'h077);
      do_reset();
      peek("post_rst", 10'h025, 0, 10'h026);
      check("post_rst_br", int'(branch_count), 0);
      check("post_rst_mp", int'(mispredict_count), 0);

      // Randomized traffic over a small PC pool that includes an aliasing pair
      for (int i = 0; i < 6; i++) pool[i] = int'($urandom_range(0, 1023));
      pool[1] = pool[0] ^ 10'h010;
      for (int i = 0; i < 600; i++) begin
         int pc;
         int fpc;
         pc  = ($urandom % 4 != 0) ? pool[$urandom % 6] : int'($urandom_range(0, 1023));
         fpc = ($urandom % 2 != 0) ? pool[$urandom % 6] : pc;
         cycle(($urandom % 4) != 0, ($urandom % 5) != 0, pc, $urandom % 2 != 0,
               int'($urandom_range(0, 1023)), $urandom % 3 == 0, fpc);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch prediction unit that sits directly upstream of the PC register in the pipelined core.
- Each cycle it takes the fetch PC and produces a predicted taken/not-taken and a next-PC candidate that steers the fetch-address mux.
- The execute stage updates it on resolution of every conditional branch (beq/bne).
- Structure: direct-mapped table of 2-bit saturating counters plus a tagged branch target buffer, and saturating performance counters.

Parameters:
- PC_W, 10, PC/instruction-address width in words (1K-word instruction memory).
- IDX_W, 4, table index width; 2^IDX_W entries, index = pc[IDX_W-1:0].
- TAG_W, PC_W-IDX_W, tag width; tag = pc[PC_W-1:IDX_W].
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  core clock, all state updates on rising edge.
- rst  in  1  asynchronous active-low reset.
- fetch_pc  in  PC_W  PC being fetched this cycle.
- pred_taken  out  1  prediction for fetch_pc, combinational.
- pred_target  out  PC_W  predicted next PC, combinational.
- upd_valid  in  1  execute stage is resolving a control instruction this cycle.
- upd_is_branch  in  1  resolved instruction is a conditional branch; jumps/jr/jal drive 0.
- upd_pc  in  PC_W  PC of the resolved instruction.
- upd_taken  in  1  actual branch outcome.
- upd_target  in  PC_W  actual branch target (PC+1+imm).
- upd_mispredict  in  1  execute stage detected that the earlier prediction was wrong.
- branch_count  out  CNT_W  conditional branches resolved.
- mispredict_count  out  CNT_W  mispredicted conditional branches.

Behaviour:
- Entry state: valid (1b), tag (TAG_W), ctr (2b), target (PC_W). The counter FSM is SNT=00, WNT=01, WT=10, ST=11.
- Reset (rst=0, asynchronous, any time including mid-update):
  - every valid=0, ctr=WNT, tag=0, target=0;
  - branch_count=0, mispredict_count=0;
  - outputs go to pred_taken=0, pred_target=fetch_pc+1 immediately.
- Lookup (purely combinational, zero latency):
  - hit = valid[idx] && tag[idx]==fetch_pc[PC_W-1:IDX_W].
  - pred_taken = hit && ctr[idx][1].
  - pred_target = pred_taken ? target[idx] : fetch_pc+1.
  - The +1 wraps modulo 2^PC_W (1023 -> 0).
- Update (registered, on the clk edge when upd_valid && upd_is_branch):
  - Hit on upd_pc:
    - taken: ctr saturating increment (ST stays ST); target <= upd_target.
    - not taken: ctr saturating decrement (SNT stays SNT); target unchanged.
  - Miss or invalid entry (allocate/replace):
    - valid<=1, tag<=upd_pc tag;
    - ctr <= upd_taken ? WT : WNT;
    - target <= upd_target.
- Counter FSM transitions:
  - taken: SNT->WNT->WT->ST->ST.
  - not taken: ST->WT->WNT->SNT->SNT.
- No update when upd_valid=0 or upd_is_branch=0; upd_taken/upd_target are don't-care in that case.
- Simultaneous lookup and update to the same index: the lookup returns the pre-update entry; the new state is visible from the next cycle. There is no bypass.
- Aliasing: PCs sharing an index but differing in tag evict each other. A lookup with a tag mismatch predicts not-taken.
- Perf counters:
  - branch_count increments on each branch update.
  - mispredict_count increments when that update also has upd_mispredict=1.
  - Both saturate at 2^CNT_W-1, with no wrap.
- upd_mispredict is ignored unless upd_valid && upd_is_branch.
- One update per cycle maximum; state is fully registered and needs no handshake.
- Flush/redirect on mispredict is owned by the pipeline control, not this block.

Test Plan:
- Reset check: assert rst=0 mid-run after training PC 0x025 to ST; release; fetch_pc=0x025 -> pred_taken=0, pred_target=0x026, both counts=0.
- Allocation: update upd_pc=0x013 taken, target 0x040 -> next cycle fetch 0x013 gives pred_taken=1, pred_target=0x040. Update 0x014 not-taken -> fetch 0x014 gives pred_taken=0, pred_target=0x015.
- Hysteresis:
  - Train 0x013 taken x3 (ST). One not-taken -> WT, still predicts taken. A second not-taken -> WNT, predicts 0x014.
  - Five not-takens leave SNT; one taken -> WNT, still predicts not-taken.
- Aliasing: train 0x013 taken (target 0x040), then update 0x023 (same idx 3) not-taken -> fetch 0x013 is now a miss (pred_target=0x014); fetch 0x023 predicts not-taken.
- Same-cycle update/lookup on idx 3: fetch_pc=0x013 during the allocating update -> pred_taken=0 that cycle, 1 the next cycle.
- Wrap and perf counters:
  - fetch_pc=0x3FF untrained -> pred_target=0x000.
  - 3 branch updates, 1 with upd_mispredict=1, plus 2 jump updates (upd_is_branch=0) -> branch_count=3, mispredict_count=1.
  - Counters forced near max (CNT_W=4 build) saturate at 15.
